// File: rtl/eth_rx_frame_check.sv
// Ethernet receive frame checker: strips preamble/SFD, forwards frame bytes as
// AXI-Stream through a one-byte hold register and flags bad frames on tlast.
module eth_rx_frame_check #(
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dv,
  input  logic       rx_er,
  input  logic [7:0] rx_data,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_bad_frame,
  input  logic       m_axis_tready,
  output logic       stat_good,
  output logic       stat_bad
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_PAYLOAD  = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RES  = 32'hDEBB20E3;

  localparam int              LEN_W   = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [1:0]       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             phy_err_q, phy_err_d;
  logic             ovf_err_q, ovf_err_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             bad_q, bad_d;
  logic             good_q, good_d;
  logic             sbad_q, sbad_d;

  logic crc_err;
  logic ovf_now;
  logic frame_bad;

  // LSB-first reflected CRC-32 over one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // A beat currently on the bus that is not accepted counts toward the verdict
  // even when the tlast decision is made in the same cycle.
  assign ovf_now   = ovf_err_q | (tvalid_q & ~m_axis_tready);
  assign crc_err   = CHECK_CRC && (crc_q != CRC_RES);
  assign frame_bad = crc_err | (len_q < LEN_MIN) | (len_q > LEN_MAX) | phy_err_q | ovf_now;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    crc_d       = crc_q;
    len_d       = len_q;
    phy_err_d   = phy_err_q;
    ovf_err_d   = ovf_now;
    tdata_d     = tdata_q;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    bad_d       = 1'b0;
    good_d      = 1'b0;
    sbad_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_dv) state_d = (rx_data == PRE_BYTE) ? ST_PREAMBLE : ST_DROP;
      end

      ST_PREAMBLE: begin
        if (!rx_dv)                   state_d = ST_IDLE;
        else if (rx_er)               state_d = ST_DROP;
        else if (rx_data == PRE_BYTE) state_d = ST_PREAMBLE;
        else if (rx_data == SFD_BYTE) begin
          state_d   = ST_PAYLOAD;
          crc_d     = CRC_INIT;
          len_d     = '0;
          phy_err_d = 1'b0;
          ovf_err_d = 1'b0;
        end else                      state_d = ST_DROP;
      end

      ST_PAYLOAD: begin
        if (rx_dv) begin
          if (hold_full_q) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_q;
          end
          hold_d      = rx_data;
          hold_full_d = 1'b1;
          crc_d       = crc32_byte(crc_q, rx_data);
          if (len_q != LEN_SAT) len_d = len_q + LEN_ONE;
          if (rx_er) phy_err_d = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          hold_full_d = 1'b0;
          // Zero-byte frames (SFD then rx_dv low) leave the hold empty and emit nothing.
          if (hold_full_q) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = hold_q;
            bad_d    = frame_bad;
            good_d   = ~frame_bad;
            sbad_d   = frame_bad;
          end
        end
      end

      ST_DROP: begin
        if (!rx_dv) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      phy_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      bad_q       <= 1'b0;
      good_q      <= 1'b0;
      sbad_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      phy_err_q   <= phy_err_d;
      ovf_err_q   <= ovf_err_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      bad_q       <= bad_d;
      good_q      <= good_d;
      sbad_q      <= sbad_d;
    end
  end

  assign m_axis_tdata     = tdata_q;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tlast_q;
  assign m_axis_bad_frame = bad_q;
  assign stat_good        = good_q;
  assign stat_bad         = sbad_q;

endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Scoreboard bench for eth_rx_frame_check: stimulus pushes expected beats,
// a monitor pops and compares each beat the DUT presents.
module tb_eth_rx_frame_check;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       bad;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] rx_data;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_bad_frame;
  logic       m_axis_tready;
  logic       stat_good;
  logic       stat_bad;

  beat_t exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  eth_rx_frame_check dut (
    .clk              (clk),
    .rst              (rst),
    .rx_dv            (rx_dv),
    .rx_er            (rx_er),
    .rx_data          (rx_data),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_bad_frame (m_axis_bad_frame),
    .m_axis_tready    (m_axis_tready),
    .stat_good        (stat_good),
    .stat_bad         (stat_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Byte-xor formulation of the Ethernet CRC used only to generate the FCS.
  function automatic logic [31:0] crc_gen(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    rx_dv   = dv;
    rx_er   = er;
    rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  // len counts destination address through FCS. Negative indices disable an option.
  task automatic send_frame(input int len, input int seed, input int flip_idx, input int er_idx,
                            input int stall_idx, input bit exp_bad, input int gap,
                            input bit stall_pre, input int abort_after);
    logic [7:0]  frm [0:1599];
    logic [31:0] crc;
    beat_t       b;
    int          n_push;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      frm[i] = 8'(i * 13 + seed * 7 + 1);
      crc    = crc_gen(crc, frm[i]);
    end
    crc = ~crc;
    frm[len-4] = crc[7:0];
    frm[len-3] = crc[15:8];
    frm[len-2] = crc[23:16];
    frm[len-1] = crc[31:24];
    if (flip_idx >= 0) frm[flip_idx] = frm[flip_idx] ^ 8'h01;

    n_push = (abort_after > 0) ? abort_after - 1 : len;
    for (int i = 0; i < n_push; i++) begin
      b.data = frm[i];
      b.last = (i == len - 1);
      b.bad  = (i == len - 1) ? exp_bad : 1'b0;
      exp_q.push_back(b);
    end

    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 8'h55);
      m_axis_tready = ~stall_pre;
    end
    drive(1'b1, 1'b0, 8'hD5);
    m_axis_tready = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (abort_after > 0 && i == abort_after) break;
      drive(1'b1, (i == er_idx), frm[i]);
      m_axis_tready = (i != stall_idx);
    end
    if (abort_after > 0) begin
      @(negedge clk);
      rst   = 1'b1;
      rx_dv = 1'b0;
      rx_er = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    idle(gap);
  endtask

  // Monitor: scoreboard compare on every cycle, away from the active edge.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("reset_outputs",
              {19'h0, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_bad_frame, stat_good, stat_bad},
              32'h0);
      end else if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {24'h0, m_axis_tdata}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("tdata",      {24'h0, m_axis_tdata},  {24'h0, e.data});
          check("tlast",      {31'h0, m_axis_tlast},  {31'h0, e.last});
          check("bad_frame",  {31'h0, m_axis_bad_frame}, {31'h0, e.bad});
          check("stat_good",  {31'h0, stat_good}, {31'h0, e.last & ~e.bad});
          check("stat_bad",   {31'h0, stat_bad},  {31'h0, e.last & e.bad});
        end
      end else begin
        check("idle_quiet", {28'h0, m_axis_tlast, m_axis_bad_frame, stat_good, stat_bad}, 32'h0);
      end
    end
  end

  // Outputs must clear on reset assertion without waiting for a clock edge.
  initial begin
    forever begin
      @(posedge rst);
      #1;
      check("async_reset",
            {19'h0, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_bad_frame, stat_good, stat_bad},
            32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d beats still expected", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    rx_dv         = 1'b0;
    rx_er         = 1'b0;
    rx_data       = 8'h00;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // len, seed, flip, er, stall, bad, gap, stall_pre, abort
    send_frame(64,   1, -1, -1, -1, 1'b0, 2, 1'b0, 0);  // good minimum-length frame
    send_frame(64,   1, 10, -1, -1, 1'b1, 2, 1'b0, 0);  // corrupted byte 10 -> CRC error
    send_frame(60,   2, -1, -1, -1, 1'b1, 2, 1'b0, 0);  // runt with valid FCS
    send_frame(1518, 3, -1, -1, -1, 1'b0, 2, 1'b0, 0);  // maximum length, good
    send_frame(1519, 4, -1, -1, -1, 1'b1, 2, 1'b0, 0);  // one byte too long
    send_frame(80,   5, -1, 20, -1, 1'b1, 2, 1'b0, 0);  // rx_er on byte 20
    send_frame(80,   6, -1, -1, 30, 1'b1, 2, 1'b0, 0);  // tready low for one beat

    // SFD directly followed by rx_dv low: nothing emitted.
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    idle(3);

    // Broken preamble then 70 bytes: dropped silently.
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 8'(i));
    idle(1);
    // tready low only outside the frame (previous tlast beat and preamble): still good.
    send_frame(64,   7, -1, -1, -1, 1'b0, 1, 1'b1, 0);

    // Back-to-back good frames, third aborted by reset, fourth clean.
    send_frame(64,   8, -1, -1, -1, 1'b0, 1, 1'b0, 0);
    send_frame(72,   9, -1, -1, -1, 1'b0, 1, 1'b0, 0);
    send_frame(100, 10, -1, -1, -1, 1'b0, 2, 1'b0, 30);
    send_frame(64,  11, -1, -1, -1, 1'b0, 4, 1'b0, 0);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
